id_ex_pipeline_register: RTL and testbench

Pipeline register between the decode (ID) and execute (EX) stages of the 5-stage MIPS core. It captures decoded operands, immediate, PC+4, instruction word and the control bundle every cycle. It inserts a bubble when the hazard detection unit drops WriteEnableMuxControl on a load-use stall, and clears its contents on a branch/jump flush. It also supports a downstream hold and keeps saturating bubble/flush event counters for debug.

---
 rtl/id_ex_pipeline_register.sv | 110 +++++++++++
 tb/tb_id_ex_pipeline_register.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Handles load-use bubbles, branch/jump flushes, downstream hold, and saturating debug event counters.
module id_ex_pipeline_register #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               WriteEnableMuxControl,
  input  logic               Flush,
  input  logic               EX_Hold,
  input  logic [31:0]        ID_Instruction,
  input  logic [31:0]        ID_PCPlus4,
  input  logic [31:0]        ID_ReadData1,
  input  logic [31:0]        ID_ReadData2,
  input  logic [31:0]        ID_SignExtImm,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_ALUSrc,
  input  logic [1:0]         ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  output logic [31:0]        EX_Instruction,
  output logic [31:0]        EX_PCPlus4,
  output logic [31:0]        EX_ReadData1,
  output logic [31:0]        EX_ReadData2,
  output logic [31:0]        EX_SignExtImm,
  output logic               EX_RegWrite,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_MemToReg,
  output logic               EX_ALUSrc,
  output logic [1:0]         EX_RegDst,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic               EX_Valid,
  output logic [CNT_W-1:0]   BubbleCount,
  output logic [CNT_W-1:0]   FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      EX_Instruction <= '0;
      EX_PCPlus4     <= '0;
      EX_ReadData1   <= '0;
      EX_ReadData2   <= '0;
      EX_SignExtImm  <= '0;
      EX_RegWrite    <= 1'b0;
      EX_MemRead     <= 1'b0;
      EX_MemWrite    <= 1'b0;
      EX_MemToReg    <= 1'b0;
      EX_ALUSrc      <= 1'b0;
      EX_RegDst      <= '0;
      EX_ALUOp       <= '0;
      EX_Valid       <= 1'b0;
      BubbleCount    <= '0;
      FlushCount     <= '0;
    end else if (Flush) begin
      // A squashed instruction leaves nothing behind, data fields included.
      EX_Instruction <= '0;
      EX_PCPlus4     <= '0;
      EX_ReadData1   <= '0;
      EX_ReadData2   <= '0;
      EX_SignExtImm  <= '0;
      EX_RegWrite    <= 1'b0;
      EX_MemRead     <= 1'b0;
      EX_MemWrite    <= 1'b0;
      EX_MemToReg    <= 1'b0;
      EX_ALUSrc      <= 1'b0;
      EX_RegDst      <= '0;
      EX_ALUOp       <= '0;
      EX_Valid       <= 1'b0;
      if (FlushCount != CNT_MAX) FlushCount <= FlushCount + CNT_ONE;
    end else if (!EX_Hold) begin
      EX_PCPlus4    <= ID_PCPlus4;
      EX_ReadData1  <= ID_ReadData1;
      EX_ReadData2  <= ID_ReadData2;
      EX_SignExtImm <= ID_SignExtImm;
      if (WriteEnableMuxControl) begin
        EX_Instruction <= ID_Instruction;
        EX_RegWrite    <= ID_RegWrite;
        EX_MemRead     <= ID_MemRead;
        EX_MemWrite    <= ID_MemWrite;
        EX_MemToReg    <= ID_MemToReg;
        EX_ALUSrc      <= ID_ALUSrc;
        EX_RegDst      <= ID_RegDst;
        EX_ALUOp       <= ID_ALUOp;
        EX_Valid       <= 1'b1;
      end else begin
        // Zeroed instruction keeps the hazard unit from re-stalling on the bubble.
        EX_Instruction <= '0;
        EX_RegWrite    <= 1'b0;
        EX_MemRead     <= 1'b0;
        EX_MemWrite    <= 1'b0;
        EX_MemToReg    <= 1'b0;
        EX_ALUSrc      <= 1'b0;
        EX_RegDst      <= '0;
        EX_ALUOp       <= '0;
        EX_Valid       <= 1'b0;
        if (BubbleCount != CNT_MAX) BubbleCount <= BubbleCount + CNT_ONE;
      end
    end
  end

  a_wemc_known: assert property (@(posedge Clock) !Reset |-> !$isunknown(WriteEnableMuxControl));

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Testbench for id_ex_pipeline_register: table vectors, hand-written hold/saturation sequences, random run.
// All results are checked against a spec-level model; a CNT_W=2 instance shares the stimulus to exercise saturation.
module tb_id_ex_pipeline_register;

  logic        clk = 1'b0;
  logic        rst, we, fl, hold;
  logic [31:0] id_instr, id_pc, id_rd1, id_rd2, id_imm;
  logic        id_rw, id_mr, id_mw, id_m2r, id_alusrc;
  logic [1:0]  id_regdst;
  logic [3:0]  id_aluop;

  logic [31:0] ex_instr, ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic        ex_rw, ex_mr, ex_mw, ex_m2r, ex_alusrc, ex_valid;
  logic [1:0]  ex_regdst;
  logic [3:0]  ex_aluop;
  logic [15:0] bub_cnt, fl_cnt;

  logic [31:0] s_instr, s_pc, s_rd1, s_rd2, s_imm;
  logic        s_rw, s_mr, s_mw, s_m2r, s_alusrc, s_valid;
  logic [1:0]  s_regdst;
  logic [3:0]  s_aluop;
  logic [1:0]  s_bub, s_fl;

  always #5 clk = ~clk;

  id_ex_pipeline_register #(.ALUOP_W(4), .CNT_W(16)) dut (
    .Clock(clk), .Reset(rst), .WriteEnableMuxControl(we), .Flush(fl), .EX_Hold(hold),
    .ID_Instruction(id_instr), .ID_PCPlus4(id_pc), .ID_ReadData1(id_rd1), .ID_ReadData2(id_rd2),
    .ID_SignExtImm(id_imm), .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_MemWrite(id_mw),
    .ID_MemToReg(id_m2r), .ID_ALUSrc(id_alusrc), .ID_RegDst(id_regdst), .ID_ALUOp(id_aluop),
    .EX_Instruction(ex_instr), .EX_PCPlus4(ex_pc), .EX_ReadData1(ex_rd1), .EX_ReadData2(ex_rd2),
    .EX_SignExtImm(ex_imm), .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr), .EX_MemWrite(ex_mw),
    .EX_MemToReg(ex_m2r), .EX_ALUSrc(ex_alusrc), .EX_RegDst(ex_regdst), .EX_ALUOp(ex_aluop),
    .EX_Valid(ex_valid), .BubbleCount(bub_cnt), .FlushCount(fl_cnt)
  );

  id_ex_pipeline_register #(.ALUOP_W(4), .CNT_W(2)) dut_small (
    .Clock(clk), .Reset(rst), .WriteEnableMuxControl(we), .Flush(fl), .EX_Hold(hold),
    .ID_Instruction(id_instr), .ID_PCPlus4(id_pc), .ID_ReadData1(id_rd1), .ID_ReadData2(id_rd2),
    .ID_SignExtImm(id_imm), .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_MemWrite(id_mw),
    .ID_MemToReg(id_m2r), .ID_ALUSrc(id_alusrc), .ID_RegDst(id_regdst), .ID_ALUOp(id_aluop),
    .EX_Instruction(s_instr), .EX_PCPlus4(s_pc), .EX_ReadData1(s_rd1), .EX_ReadData2(s_rd2),
    .EX_SignExtImm(s_imm), .EX_RegWrite(s_rw), .EX_MemRead(s_mr), .EX_MemWrite(s_mw),
    .EX_MemToReg(s_m2r), .EX_ALUSrc(s_alusrc), .EX_RegDst(s_regdst), .EX_ALUOp(s_aluop),
    .EX_Valid(s_valid), .BubbleCount(s_bub), .FlushCount(s_fl)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what EX should hold, plus unbounded event totals.
  logic [31:0] m_instr, m_pc, m_rd1, m_rd2, m_imm;
  logic        m_rw, m_mr, m_mw, m_m2r, m_alusrc, m_valid;
  logic [1:0]  m_regdst;
  logic [3:0]  m_aluop;
  int          m_bub, m_fl;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_ctrl();
    m_instr = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_alusrc = 0;
    m_regdst = 0; m_aluop = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      clear_ctrl(); m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_bub = 0; m_fl = 0;
    end else if (fl) begin
      clear_ctrl(); m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_fl++;
    end else if (!hold) begin
      m_pc = id_pc; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      if (we) begin
        m_instr = id_instr; m_rw = id_rw; m_mr = id_mr; m_mw = id_mw; m_m2r = id_m2r;
        m_alusrc = id_alusrc; m_regdst = id_regdst; m_aluop = id_aluop; m_valid = 1;
      end else begin
        clear_ctrl(); m_bub++;
      end
    end
  endtask

  task automatic check_all();
    chk("instr", ex_instr, m_instr);     chk("pc4", ex_pc, m_pc);
    chk("rd1", ex_rd1, m_rd1);           chk("rd2", ex_rd2, m_rd2);
    chk("imm", ex_imm, m_imm);           chk("regwrite", 32'(ex_rw), 32'(m_rw));
    chk("memread", 32'(ex_mr), 32'(m_mr)); chk("memwrite", 32'(ex_mw), 32'(m_mw));
    chk("memtoreg", 32'(ex_m2r), 32'(m_m2r)); chk("alusrc", 32'(ex_alusrc), 32'(m_alusrc));
    chk("regdst", 32'(ex_regdst), 32'(m_regdst)); chk("aluop", 32'(ex_aluop), 32'(m_aluop));
    chk("valid", 32'(ex_valid), 32'(m_valid));
    chk("bubble_cnt", 32'(bub_cnt), 32'(sat(m_bub, 65535)));
    chk("flush_cnt", 32'(fl_cnt), 32'(sat(m_fl, 65535)));
    chk("s_instr", s_instr, m_instr);    chk("s_valid", 32'(s_valid), 32'(m_valid));
    chk("s_bubble_cnt", 32'(s_bub), 32'(sat(m_bub, 3)));
    chk("s_flush_cnt", 32'(s_fl), 32'(sat(m_fl, 3)));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    id_instr = $urandom; id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
    id_imm = $urandom; id_rw = 1'($urandom); id_mr = 1'($urandom); id_mw = 1'($urandom);
    id_m2r = 1'($urandom); id_alusrc = 1'($urandom); id_regdst = 2'($urandom_range(0, 2));
    id_aluop = 4'($urandom);
  endtask

  typedef struct {
    logic        rst, we, fl, hold;
    logic [31:0] instr, rd1;
    logic        mr, rw;
    logic [3:0]  aluop;
    logic [31:0] e_instr, e_rd1;
    logic        e_mr, e_rw, e_valid;
    int          e_bub, e_fl;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 1, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1, 4'hF, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1, 4'hF, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 32'h8C22_0004, 32'h10, 1, 0, 4'h0, 32'h8C22_0004, 32'h10, 1, 0, 1, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 32'h0042_1020, 32'h20, 0, 1, 4'h2, 0, 32'h20, 0, 0, 0, 1, 0};
    vecs[4] = '{0, 1, 0, 0, 32'h0042_1020, 32'h20, 0, 1, 4'h2, 32'h0042_1020, 32'h20, 0, 1, 1, 1, 0};
    vecs[5] = '{0, 0, 1, 0, 32'h0042_1020, 32'h30, 1, 1, 4'h2, 0, 0, 0, 0, 0, 1, 1};

    rst = 1; we = 1; fl = 0; hold = 0;
    id_instr = 0; id_pc = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
    id_rw = 0; id_mr = 0; id_mw = 0; id_m2r = 0; id_alusrc = 0; id_regdst = 0; id_aluop = 0;
    m_bub = 0; m_fl = 0;

    // Directed table: reset, lw, load-use bubble, reload, flush-beats-bubble.
    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst; we = vecs[i].we; fl = vecs[i].fl; hold = vecs[i].hold;
      id_instr = vecs[i].instr; id_rd1 = vecs[i].rd1; id_mr = vecs[i].mr; id_rw = vecs[i].rw;
      id_aluop = vecs[i].aluop; id_pc = 32'h0040_0000 + 32'(i * 4); id_rd2 = 32'hA5A5_0000 + 32'(i);
      id_imm = 32'h4; id_mw = vecs[i].rst; id_m2r = 1; id_alusrc = 1; id_regdst = 2'd1;
      step();
      chk("vec_instr", ex_instr, vecs[i].e_instr);
      chk("vec_rd1", ex_rd1, vecs[i].e_rd1);
      chk("vec_memread", 32'(ex_mr), 32'(vecs[i].e_mr));
      chk("vec_regwrite", 32'(ex_rw), 32'(vecs[i].e_rw));
      chk("vec_valid", 32'(ex_valid), 32'(vecs[i].e_valid));
      chk("vec_bubble_cnt", 32'(bub_cnt), 32'(vecs[i].e_bub));
      chk("vec_flush_cnt", 32'(fl_cnt), 32'(vecs[i].e_fl));
    end

    // Hold for three cycles with changing inputs, then flush during hold.
    we = 1; fl = 0; hold = 0;
    id_instr = 32'h2008_0005; id_pc = 32'h0040_0100; id_rd1 = 32'h77; id_rw = 1; id_mr = 0;
    step();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      we = 1'($urandom);
      step();
      chk("hold_instr", ex_instr, 32'h2008_0005);
      chk("hold_pc4", ex_pc, 32'h0040_0100);
      chk("hold_valid", 32'(ex_valid), 32'd1);
      chk("hold_bubble_cnt", 32'(bub_cnt), 32'd1);
      chk("hold_flush_cnt", 32'(fl_cnt), 32'd1);
    end
    fl = 1;
    step();
    chk("hold_flush_instr", ex_instr, 32'h0);
    chk("hold_flush_valid", 32'(ex_valid), 32'd0);
    chk("hold_flush_cnt", 32'(fl_cnt), 32'd2);

    // Saturation on the 2-bit instance: 1,2,3,3,3, then reset clears it.
    hold = 0; fl = 0; rst = 1;
    step();
    rst = 0; we = 0;
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      step();
      chk("sat_bubble_cnt", 32'(s_bub), 32'(sat(i + 1, 3)));
    end
    rst = 1;
    step();
    chk("sat_after_reset", 32'(s_bub), 32'd0);
    rst = 0;

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 49) == 0);
      fl = ($urandom_range(0, 7) == 0);
      hold = ($urandom_range(0, 5) == 0);
      we = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
